// File: rtl/icu_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : icu_sequencer_if
// Purpose  : Sequencer bundle: program-memory fetch handshake, run enable,
//            and the opcode/operand/valid/halt outputs to the control unit.
// Revision : 1.0 - initial release
// ============================================================================
interface icu_sequencer_if #(
    parameter int PC_W = 8
);
    logic            run;
    logic [PC_W-1:0] mem_addr;
    logic            mem_req;
    logic [7:0]      mem_data;
    logic            mem_ready;
    logic [3:0]      I;
    logic [3:0]      io_addr;
    logic            inst_valid;
    logic            halt;

    // Sequencer side
    modport master (
        input  run, mem_data, mem_ready,
        output mem_addr, mem_req, I, io_addr, inst_valid, halt
    );

    // Memory / control-unit / environment side
    modport slave (
        output run, mem_data, mem_ready,
        input  mem_addr, mem_req, I, io_addr, inst_valid, halt
    );
endinterface
`default_nettype wire

// File: rtl/icu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : icu_sequencer
// Purpose  : Program sequencer ahead of the control unit. Fetches 8-bit words,
//            forwards opcodes 0x0-0xB, executes JMP/JSR/RTN/HLT locally while
//            presenting NOP (I=0) to the control unit. All outputs registered.
// Revision : 1.0 - initial release
// ============================================================================
module icu_sequencer #(
    parameter int PC_W = 8
) (
    input  wire logic            clk,
    input  wire logic            rst,
    icu_sequencer_if.master      bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_TFETCH = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    localparam logic [3:0]      c_op_jmp = 4'hC;
    localparam logic [3:0]      c_op_jsr = 4'hD;
    localparam logic [3:0]      c_op_rtn = 4'hE;
    localparam logic [3:0]      c_op_hlt = 4'hF;
    localparam logic [PC_W-1:0] c_pc_one = {{(PC_W-1){1'b0}}, 1'b1};

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] ret_q, ret_d;
    logic [3:0]      op_q, op_d;
    logic [PC_W-1:0] mem_addr_q, mem_addr_d;
    logic            mem_req_q, mem_req_d;
    logic [3:0]      i_out_q, i_out_d;
    logic [3:0]      io_addr_q, io_addr_d;
    logic            inst_valid_q, inst_valid_d;
    logic            halt_q, halt_d;

    logic            w_accept;
    assign w_accept = mem_req_q & bus.mem_ready;

    // State and registered outputs; reset clears everything asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= '0;
            ret_q        <= '0;
            op_q         <= '0;
            mem_addr_q   <= '0;
            mem_req_q    <= 1'b0;
            i_out_q      <= '0;
            io_addr_q    <= '0;
            inst_valid_q <= 1'b0;
            halt_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ret_q        <= ret_d;
            op_q         <= op_d;
            mem_addr_q   <= mem_addr_d;
            mem_req_q    <= mem_req_d;
            i_out_q      <= i_out_d;
            io_addr_q    <= io_addr_d;
            inst_valid_q <= inst_valid_d;
            halt_q       <= halt_d;
        end
    end

    // Next state; outputs are computed one cycle ahead so they appear
    // registered in the state they belong to
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ret_d        = ret_q;
        op_d         = op_q;
        mem_addr_d   = mem_addr_q;
        mem_req_d    = 1'b0;
        i_out_d      = 4'h0;
        io_addr_d    = io_addr_q;
        inst_valid_d = 1'b0;
        halt_d       = halt_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.run) begin
                    state_d    = ST_FETCH;
                    mem_req_d  = 1'b1;
                    mem_addr_d = pc_q;
                end
            end

            ST_FETCH: begin
                // Request and address held until the word is accepted
                mem_req_d = 1'b1;
                if (w_accept) begin
                    mem_req_d = 1'b0;
                    op_d      = bus.mem_data[7:4];
                    pc_d      = pc_q + c_pc_one;
                    state_d   = ST_ISSUE;
                    if (bus.mem_data[7:4] < c_op_jmp) begin
                        i_out_d      = bus.mem_data[7:4];
                        io_addr_d    = bus.mem_data[3:0];
                        inst_valid_d = 1'b1;
                    end
                end
            end

            ST_ISSUE: begin
                if (op_q == c_op_jmp || op_q == c_op_jsr) begin
                    state_d    = ST_TFETCH;
                    mem_req_d  = 1'b1;
                    mem_addr_d = pc_q;
                end else if (op_q == c_op_hlt) begin
                    state_d = ST_HALT;
                    halt_d  = 1'b1;
                end else begin
                    if (op_q == c_op_rtn) begin
                        pc_d = ret_q;
                    end
                    if (bus.run) begin
                        state_d    = ST_FETCH;
                        mem_req_d  = 1'b1;
                        mem_addr_d = pc_d;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_TFETCH: begin
                mem_req_d = 1'b1;
                if (w_accept) begin
                    mem_req_d = 1'b0;
                    pc_d      = bus.mem_data[PC_W-1:0];
                    // Return lands on the word after the target word
                    if (op_q == c_op_jsr) begin
                        ret_d = pc_q + c_pc_one;
                    end
                    if (bus.run) begin
                        state_d    = ST_FETCH;
                        mem_req_d  = 1'b1;
                        mem_addr_d = pc_d;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_HALT: begin
                halt_d = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.I          = i_out_q;
    assign bus.io_addr    = io_addr_q;
    assign bus.inst_valid = inst_valid_q;
    assign bus.halt       = halt_q;

endmodule
`default_nettype wire

// File: tb/tb_icu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_icu_sequencer
// Purpose  : Self-checking bench for icu_sequencer (PC_W=8 and PC_W=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_icu_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    icu_sequencer_if #(.PC_W(8)) bus8();
    icu_sequencer_if #(.PC_W(4)) bus4();

    icu_sequencer #(.PC_W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    icu_sequencer #(.PC_W(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    logic [7:0] rom8 [256];
    logic [7:0] rom4 [16];
    logic ready8 = 1'b1, run8 = 1'b0;
    logic ready4 = 1'b1, run4 = 1'b0;

    assign bus8.mem_data  = rom8[bus8.mem_addr];
    assign bus8.mem_ready = ready8;
    assign bus8.run       = run8;
    assign bus4.mem_data  = rom4[bus4.mem_addr];
    assign bus4.mem_ready = ready4;
    assign bus4.run       = run4;

    typedef struct packed { logic [3:0] i; logic [3:0] io; } iss_t;
    typedef struct { logic [7:0] word; logic [3:0] ei; logic [3:0] eio; } vec_t;

    iss_t exp_q[$];
    int   exp_addr_q[$];
    int   iss_cyc_q[$];
    int   total = 0, passed = 0, nop_viol = 0, cyc = 0, start_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    endtask

    // Issue scoreboard: each inst_valid pulse pops one expected (I, io_addr)
    always @(negedge clk) begin
        iss_t e;
        if (!rst) begin
            if (bus8.inst_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_issue: actual I=%0h io=%0h required no issue",
                             bus8.I, bus8.io_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("issue_I", int'(bus8.I), int'(e.i));
                    chk("issue_io", int'(bus8.io_addr), int'(e.io));
                    iss_cyc_q.push_back(cyc);
                end
            end else if (bus8.I != 4'h0) begin
                nop_viol++;
            end
        end
    end

    // Fetch scoreboard: each accepted request pops one expected address
    always @(negedge clk) begin
        #1;
        if (!rst && bus8.mem_req && bus8.mem_ready) begin
            if (exp_addr_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_fetch: actual addr=%0h required no fetch", bus8.mem_addr);
            end else begin
                chk("fetch_addr", int'(bus8.mem_addr), exp_addr_q.pop_front());
            end
        end
    end

    task automatic do_reset();
        run8 = 1'b0;
        run4 = 1'b0;
        rst  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic fill8();
        for (int k = 0; k < 256; k++) rom8[k] = 8'hF0;
    endtask

    task automatic start8();
        iss_cyc_q.delete();
        start_cyc = cyc;
        run8 = 1'b1;
    endtask

    task automatic finish_prog(input string name);
        for (int g = 0; g < 200 && !bus8.halt; g++) @(negedge clk);
        chk({name, "_halt"}, int'(bus8.halt), 1);
        chk({name, "_issues_left"}, exp_q.size(), 0);
        chk({name, "_fetches_left"}, exp_addr_q.size(), 0);
        exp_q.delete();
        exp_addr_q.delete();
    endtask

    vec_t tbl [6];
    int   n_req, waits;
    bit   done;

    initial begin
        for (int k = 0; k < 16; k++) rom4[k] = 8'hF0;
        tbl[0] = '{8'h13, 4'h1, 4'h3};
        tbl[1] = '{8'h85, 4'h8, 4'h5};
        tbl[2] = '{8'h2A, 4'h2, 4'hA};
        tbl[3] = '{8'h00, 4'h0, 4'h0};
        tbl[4] = '{8'hBF, 4'hB, 4'hF};
        tbl[5] = '{8'h7C, 4'h7, 4'hC};

        // ---- Reset values ----
        do_reset();
        chk("rst_mem_req", int'(bus8.mem_req), 0);
        chk("rst_I", int'(bus8.I), 0);
        chk("rst_halt", int'(bus8.halt), 0);

        // ---- Straight-line programs from the vector table ----
        for (int p = 0; p < 2; p++) begin
            do_reset();
            fill8();
            for (int k = 0; k < 3; k++) begin
                rom8[k] = tbl[p*3+k].word;
                exp_q.push_back({tbl[p*3+k].ei, tbl[p*3+k].eio});
                exp_addr_q.push_back(k);
            end
            exp_addr_q.push_back(3);
            nop_viol = 0;
            start8();
            finish_prog("straight");
            chk("straight_nop", nop_viol, 0);
            if (iss_cyc_q.size() == 3) begin
                chk("first_issue_latency", iss_cyc_q[0] - start_cyc, 2);
                chk("issue_spacing_1", iss_cyc_q[1] - iss_cyc_q[0], 2);
                chk("issue_spacing_2", iss_cyc_q[2] - iss_cyc_q[1], 2);
            end else begin
                chk("straight_issue_count", iss_cyc_q.size(), 3);
            end
        end

        // ---- Wait states on the first fetch ----
        do_reset();
        fill8();
        for (int k = 0; k < 3; k++) begin
            rom8[k] = tbl[k].word;
            exp_q.push_back({tbl[k].ei, tbl[k].eio});
            exp_addr_q.push_back(k);
        end
        exp_addr_q.push_back(3);
        ready8 = 1'b0;
        start8();
        n_req = 0;
        done  = 1'b0;
        for (int g = 0; g < 20 && !done; g++) begin
            @(negedge clk);
            if (bus8.mem_req) begin
                n_req++;
                if (n_req <= 3) chk("wait_addr_hold", int'(bus8.mem_addr), 0);
                else begin ready8 = 1'b1; done = 1'b1; end
            end
        end
        chk("wait_reached", int'(done), 1);
        ready8 = 1'b1;
        finish_prog("wait");
        if (iss_cyc_q.size() > 0) chk("wait_first_issue", iss_cyc_q[0] - start_cyc, 5);
        else chk("wait_issue_count", iss_cyc_q.size(), 3);

        // ---- Call / return ----
        do_reset();
        fill8();
        rom8[8'h00] = 8'hD0; rom8[8'h01] = 8'h10;
        rom8[8'h10] = 8'h47; rom8[8'h11] = 8'hE0;
        rom8[8'h02] = 8'h55;
        exp_q.push_back({4'h4, 4'h7});
        exp_q.push_back({4'h5, 4'h5});
        foreach (tbl[k]) if (k < 0) exp_addr_q.push_back(0);
        exp_addr_q.push_back(8'h00); exp_addr_q.push_back(8'h01);
        exp_addr_q.push_back(8'h10); exp_addr_q.push_back(8'h11);
        exp_addr_q.push_back(8'h02); exp_addr_q.push_back(8'h03);
        nop_viol = 0;
        start8();
        finish_prog("callret");
        chk("callret_nop", nop_viol, 0);
        if (iss_cyc_q.size() > 0) chk("jsr_latency", iss_cyc_q[0] - start_cyc, 5);

        // ---- Halt ----
        do_reset();
        fill8();
        exp_addr_q.push_back(0);
        start8();
        @(negedge clk);
        @(negedge clk);
        chk("halt_in_issue", int'(bus8.halt), 0);
        @(negedge clk);
        chk("halt_after_issue", int'(bus8.halt), 1);
        waits = 0;
        for (int g = 0; g < 10; g++) begin
            @(negedge clk);
            if (bus8.mem_req || !bus8.halt || bus8.I != 4'h0) waits++;
        end
        chk("halt_sticky_no_req", waits, 0);
        chk("halt_fetches_left", exp_addr_q.size(), 0);
        rst = 1'b1;
        #1;
        chk("halt_cleared_by_rst", int'(bus8.halt), 0);

        // ---- Reset mid-fetch ----
        do_reset();
        fill8();
        rom8[0] = 8'h13; rom8[1] = 8'h85;
        exp_q.push_back({4'h1, 4'h3});
        exp_addr_q.push_back(0);
        start8();
        done = 1'b0;
        for (int g = 0; g < 10 && !done; g++) begin
            @(negedge clk);
            if (bus8.inst_valid) begin ready8 = 1'b0; done = 1'b1; end
        end
        chk("midfetch_issue_seen", int'(done), 1);
        @(negedge clk);
        chk("midfetch_req", int'(bus8.mem_req), 1);
        chk("midfetch_addr", int'(bus8.mem_addr), 1);
        rst  = 1'b1;
        run8 = 1'b0;
        #1;
        chk("arst_mem_req", int'(bus8.mem_req), 0);
        chk("arst_mem_addr", int'(bus8.mem_addr), 0);
        chk("arst_io_addr", int'(bus8.io_addr), 0);
        chk("arst_inst_valid", int'(bus8.inst_valid), 0);
        ready8 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        waits = 0;
        for (int g = 0; g < 10; g++) begin
            @(negedge clk);
            if (bus8.mem_req || bus8.I != 4'h0 || bus8.halt || bus8.inst_valid) waits++;
        end
        chk("idle_after_reset", waits, 0);
        chk("midfetch_issues_left", exp_q.size(), 0);
        chk("midfetch_fetches_left", exp_addr_q.size(), 0);
        exp_q.delete();
        exp_addr_q.delete();

        // ---- PC wrap on the 4-bit instance ----
        do_reset();
        rom4[4'h0] = 8'hC0;
        rom4[4'h1] = 8'hAF;   // upper bits of the target word are ignored
        rom4[4'hF] = 8'h31;
        start_cyc = cyc;
        run4 = 1'b1;
        done = 1'b0;
        for (int g = 0; g < 20 && !done; g++) begin
            @(negedge clk);
            if (bus4.inst_valid) begin
                done = 1'b1;
                chk("wrap_I", int'(bus4.I), 3);
                chk("wrap_io", int'(bus4.io_addr), 1);
                chk("wrap_latency", cyc - start_cyc, 5);
            end
        end
        chk("wrap_issue_seen", int'(done), 1);
        done = 1'b0;
        for (int g = 0; g < 5 && !done; g++) begin
            @(negedge clk);
            if (bus4.mem_req) begin
                done = 1'b1;
                chk("wrap_next_addr", int'(bus4.mem_addr), 0);
            end
        end
        chk("wrap_next_fetch_seen", int'(done), 1);
        run4 = 1'b0;
        repeat (10) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
